// File: rtl/sd_flow_checker_if.sv
// Consumer- and producer-side srdy/drdy handshakes of one monitored sd block.
interface sd_flow_checker_if #(
  parameter int unsigned width = 16
);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;

  modport master (output c_srdy, c_drdy, c_data, p_srdy, p_drdy, p_data);
  modport slave  (input  c_srdy, c_drdy, c_data, p_srdy, p_drdy, p_data);
endinterface

// File: rtl/sd_flow_checker.sv
// Passive srdy/drdy flow checker: transfer counts, in-order scoreboard and
// sticky protocol/ordering/capacity/liveness error flags.
module sd_flow_checker #(
  parameter int unsigned width       = 16,
  parameter int unsigned depth       = 8,
  parameter int unsigned max_latency = 32,
  parameter bit          check_data  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  sd_flow_checker_if.slave           mon,
  output logic [31:0]                in_count,
  output logic [31:0]                out_count,
  output logic [$clog2(depth+1)-1:0] occupancy,
  output logic                       err_hold,
  output logic                       err_order,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       err_timeout,
  output logic                       err
);
  localparam int unsigned OW = $clog2(depth + 1);
  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned LW = (max_latency > 0) ? $clog2(max_latency + 1) : 1;

  logic             ci, po;
  logic             push, pop, cmp_en;
  logic [width-1:0] exp_data;

  logic [31:0]      in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    wait_q, wait_d;
  logic             stall_q, stall_d;
  logic [width-1:0] stall_data_q, stall_data_d;
  logic             err_hold_q, err_hold_d;
  logic             err_order_q, err_order_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_underflow_q, err_underflow_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_q, err_d;
  logic [width-1:0] mem_q [depth];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign ci = mon.c_srdy & mon.c_drdy;
  assign po = mon.p_srdy & mon.p_drdy;

  // Next-state for counters, scoreboard bookkeeping and sticky flags.
  always_comb begin
    in_cnt_d        = in_cnt_q + 32'(ci);
    out_cnt_d       = out_cnt_q + 32'(po);
    occ_d           = occ_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    wait_d          = wait_q;
    push            = 1'b0;
    pop             = 1'b0;
    cmp_en          = 1'b0;
    exp_data        = mem_q[rd_ptr_q];
    stall_d         = mon.p_srdy & ~mon.p_drdy;
    stall_data_d    = mon.p_data;
    err_hold_d      = err_hold_q;
    err_order_d     = err_order_q;
    err_overflow_d  = err_overflow_q;
    err_underflow_d = err_underflow_q;
    err_timeout_d   = err_timeout_q;

    if (ci && po) begin
      cmp_en = 1'b1;
      if (occ_q == '0) begin
        exp_data = mon.c_data;
      end else begin
        push = 1'b1;
        pop  = 1'b1;
      end
    end else if (ci) begin
      if (occ_q == OW'(depth)) begin
        err_overflow_d = 1'b1;
      end else begin
        push  = 1'b1;
        occ_d = occ_q + OW'(1);
      end
    end else if (po) begin
      if (occ_q == '0) begin
        err_underflow_d = 1'b1;
      end else begin
        pop    = 1'b1;
        cmp_en = 1'b1;
        occ_d  = occ_q - OW'(1);
      end
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    if (check_data && cmp_en && (mon.p_data != exp_data)) err_order_d = 1'b1;

    if (stall_q && (!mon.p_srdy || (mon.p_data != stall_data_q))) err_hold_d = 1'b1;

    // Backpressure (p_drdy low) freezes the wait counter rather than clearing it.
    if (po || (occ_q == '0)) begin
      wait_d = '0;
    end else if (mon.p_drdy && (wait_q != LW'(max_latency))) begin
      wait_d = wait_q + LW'(1);
    end
    if ((max_latency != 0) && (wait_d == LW'(max_latency))) err_timeout_d = 1'b1;

    err_d = err_hold_d | err_order_d | err_overflow_d | err_underflow_d | err_timeout_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q        <= '0;
      out_cnt_q       <= '0;
      occ_q           <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      wait_q          <= '0;
      stall_q         <= 1'b0;
      stall_data_q    <= '0;
      err_hold_q      <= 1'b0;
      err_order_q     <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      in_cnt_q        <= in_cnt_d;
      out_cnt_q       <= out_cnt_d;
      occ_q           <= occ_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      wait_q          <= wait_d;
      stall_q         <= stall_d;
      stall_data_q    <= stall_data_d;
      err_hold_q      <= err_hold_d;
      err_order_q     <= err_order_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_timeout_q   <= err_timeout_d;
      err_q           <= err_d;
    end
  end

  // Scoreboard storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (check_data && push) mem_q[wr_ptr_q] <= mon.c_data;
  end

  assign in_count      = in_cnt_q;
  assign out_count     = out_cnt_q;
  assign occupancy     = occ_q;
  assign err_hold      = err_hold_q;
  assign err_order     = err_order_q;
  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
  assign err_timeout   = err_timeout_q;
  assign err           = err_q;

`ifdef FORMAL
  always_comb begin
    if (!reset) begin
      assert (!err_hold_q);
      assert (!err_order_q);
      assert (!err_overflow_q);
      assert (!err_underflow_q);
      assert (!err_timeout_q);
    end
  end
`endif
endmodule

// File: tb/tb_sd_flow_checker.sv
// Bench for sd_flow_checker: directed vector table, then passthrough and FIFO-model random traffic.
module tb_sd_flow_checker;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned ML = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_count, out_count;
  logic [2:0]  occupancy;
  logic        err_hold, err_order, err_overflow, err_underflow, err_timeout, err;

  always #5 clk = ~clk;

  sd_flow_checker_if #(.width(W)) bus ();

  sd_flow_checker #(.width(W), .depth(D), .max_latency(ML), .check_data(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .mon          (bus),
    .in_count     (in_count),
    .out_count    (out_count),
    .occupancy    (occupancy),
    .err_hold     (err_hold),
    .err_order    (err_order),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .err_timeout  (err_timeout),
    .err          (err)
  );

  // flg bit order: {timeout, underflow, overflow, order, hold}
  typedef struct {
    logic        rst;
    logic        cs, cd;
    logic [15:0] cdat;
    logic        ps, pd;
    logic [15:0] pdat;
    logic [2:0]  occ;
    logic [4:0]  flg;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] inc, outc;
    logic [2:0]  occ;
    logic [4:0]  flg;
    string       name;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_in = '0;
  logic [31:0] m_out = '0;

  function automatic vec_t mk(input logic rst, cs, cd, input logic [15:0] cdat,
                              input logic ps, pd, input logic [15:0] pdat,
                              input logic [2:0] occ, input logic [4:0] flg, input string name);
    vec_t v;
    v.rst = rst; v.cs = cs; v.cd = cd; v.cdat = cdat;
    v.ps = ps; v.pd = pd; v.pdat = pdat; v.occ = occ; v.flg = flg; v.name = name;
    return v;
  endfunction

  function automatic void add(input logic rst, cs, cd, input logic [15:0] cdat,
                              input logic ps, pd, input logic [15:0] pdat,
                              input logic [2:0] occ, input logic [4:0] flg, input string name);
    tbl.push_back(mk(rst, cs, cd, cdat, ps, pd, pdat, occ, flg, name));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    reset       = v.rst;
    bus.c_srdy  = v.cs;
    bus.c_drdy  = v.cd;
    bus.c_data  = v.cdat;
    bus.p_srdy  = v.ps;
    bus.p_drdy  = v.pd;
    bus.p_data  = v.pdat;
    if (v.rst) begin
      m_in  = '0;
      m_out = '0;
    end else begin
      m_in  = m_in + 32'(v.cs & v.cd);
      m_out = m_out + 32'(v.ps & v.pd);
    end
    e.inc = m_in; e.outc = m_out; e.occ = v.occ; e.flg = v.flg; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, " in_count"}, in_count, e.inc);
    chk({e.name, " out_count"}, out_count, e.outc);
    chk({e.name, " occupancy"}, 32'(occupancy), 32'(e.occ));
    chk({e.name, " flags"}, 32'({err_timeout, err_underflow, err_overflow, err_order, err_hold}),
        32'(e.flg));
    chk({e.name, " err"}, 32'(err), 32'(|e.flg));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic        src_v;
    logic [15:0] src_d;
    logic        pd_r, cdr, ps_r, ci, po;
    logic [15:0] pdat_r;
    logic [15:0] fq[$];
    int          sent, cyc;

    reset = 1'b1;
    bus.c_srdy = 1'b0; bus.c_drdy = 1'b0; bus.c_data = '0;
    bus.p_srdy = 1'b0; bus.p_drdy = 1'b0; bus.p_data = '0;

    // Overflow at depth 4; the dropped 5th item must not disturb the remaining order.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_a");
    add(0, 1, 1, 16'h0001, 0, 0, 16'h0, 1, 5'b00000, "ovf_push1");
    add(0, 1, 1, 16'h0002, 0, 0, 16'h0, 2, 5'b00000, "ovf_push2");
    add(0, 1, 1, 16'h0003, 0, 0, 16'h0, 3, 5'b00000, "ovf_push3");
    add(0, 1, 1, 16'h0004, 0, 0, 16'h0, 4, 5'b00000, "ovf_push4");
    add(0, 1, 1, 16'h0005, 0, 0, 16'h0, 4, 5'b00100, "ovf_push5");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0001, 3, 5'b00100, "ovf_pop1");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0002, 2, 5'b00100, "ovf_pop2");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0003, 1, 5'b00100, "ovf_pop3");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0004, 0, 5'b00100, "ovf_pop4");
    // Order mismatch then underflow.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_b");
    add(0, 1, 1, 16'h1234, 0, 0, 16'h0, 1, 5'b00000, "ord_push1");
    add(0, 1, 1, 16'h5678, 0, 0, 16'h0, 2, 5'b00000, "ord_push2");
    add(0, 0, 0, 16'h0, 1, 1, 16'h5678, 1, 5'b00010, "ord_bad");
    add(0, 0, 0, 16'h0, 1, 1, 16'h5678, 0, 5'b00010, "ord_pop2");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0, 0, 5'b01010, "underflow");
    // Bypass compare with mismatching data.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_c");
    add(0, 1, 1, 16'h0011, 1, 1, 16'h0012, 0, 5'b00010, "bypass_bad");
    // Simultaneous push/pop at partial and full occupancy, wrapping pointers.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_d");
    add(0, 1, 1, 16'h0001, 0, 0, 16'h0, 1, 5'b00000, "pp_push1");
    add(0, 1, 1, 16'h0002, 1, 1, 16'h0001, 1, 5'b00000, "pp_both1");
    add(0, 1, 1, 16'h0003, 0, 0, 16'h0, 2, 5'b00000, "pp_push3");
    add(0, 1, 1, 16'h0004, 0, 0, 16'h0, 3, 5'b00000, "pp_push4");
    add(0, 1, 1, 16'h0005, 0, 0, 16'h0, 4, 5'b00000, "pp_push5");
    add(0, 1, 1, 16'h0006, 1, 1, 16'h0002, 4, 5'b00000, "pp_both_full");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0003, 3, 5'b00000, "pp_pop3");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0004, 2, 5'b00000, "pp_pop4");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0005, 1, 5'b00000, "pp_pop5");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0006, 0, 5'b00000, "pp_pop6");
    // Hold: data change, legal hold, reset suppression, srdy drop.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_e");
    add(0, 0, 0, 16'h0, 1, 0, 16'hAAAA, 0, 5'b00000, "hold_stall");
    add(0, 0, 0, 16'h0, 1, 0, 16'hAAAB, 0, 5'b00001, "hold_change");
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_f");
    add(0, 1, 1, 16'hAAAA, 0, 0, 16'h0, 1, 5'b00000, "hold_ok_push");
    add(0, 0, 0, 16'h0, 1, 0, 16'hAAAA, 1, 5'b00000, "hold_ok_s1");
    add(0, 0, 0, 16'h0, 1, 0, 16'hAAAA, 1, 5'b00000, "hold_ok_s2");
    add(0, 0, 0, 16'h0, 1, 1, 16'hAAAA, 0, 5'b00000, "hold_ok_pop");
    add(0, 0, 0, 16'h0, 1, 0, 16'h1234, 0, 5'b00000, "hold_rs_stall");
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "hold_rs_reset");
    add(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "hold_rs_idle");
    add(0, 0, 0, 16'h0, 1, 0, 16'hBBBB, 0, 5'b00000, "hold_drop_stall");
    add(0, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00001, "hold_drop");
    // Timeout after 8 ready cycles.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_g");
    add(0, 1, 1, 16'h0007, 0, 0, 16'h0, 1, 5'b00000, "to_push");
    for (int i = 0; i < 7; i++) add(0, 0, 0, 16'h0, 0, 1, 16'h0, 1, 5'b00000, "to_wait");
    add(0, 0, 0, 16'h0, 0, 1, 16'h0, 1, 5'b10000, "to_fire");
    // Backpressure never times out and freezes the count.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_h");
    add(0, 1, 1, 16'h0007, 0, 0, 16'h0, 1, 5'b00000, "bp_push");
    for (int i = 0; i < 20; i++) add(0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 5'b00000, "bp_stall");
    for (int i = 0; i < 7; i++) add(0, 0, 0, 16'h0, 0, 1, 16'h0, 1, 5'b00000, "bp_ready");
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0, 0, 0, 16'h0, 1, 5'b00000, "bp_pause");
    add(0, 0, 0, 16'h0, 0, 1, 16'h0, 1, 5'b10000, "bp_fire");
    // Reset with 3 in flight and err_order set, then a clean fresh item.
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_i");
    add(0, 1, 1, 16'h000A, 0, 0, 16'h0, 1, 5'b00000, "mr_push1");
    add(0, 1, 1, 16'h000B, 0, 0, 16'h0, 2, 5'b00000, "mr_push2");
    add(0, 1, 1, 16'h000C, 0, 0, 16'h0, 3, 5'b00000, "mr_push3");
    add(0, 1, 1, 16'h000D, 0, 0, 16'h0, 4, 5'b00000, "mr_push4");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0099, 3, 5'b00010, "mr_bad");
    add(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "mr_reset");
    add(0, 1, 1, 16'h0055, 1, 1, 16'h0055, 0, 5'b00000, "mr_bypass");
    add(0, 1, 1, 16'h0066, 0, 0, 16'h0, 1, 5'b00000, "mr_push");
    add(0, 0, 0, 16'h0, 1, 1, 16'h0066, 0, 5'b00000, "mr_pop");

    @(negedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // Passthrough DUT: 100 items under random source and sink stalls.
    step(mk(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_pass"));
    src_v = 1'b0; src_d = '0; sent = 0; cyc = 0;
    while (sent < 100 && cyc < 3000) begin
      if (!src_v && $urandom_range(0, 1) == 1) begin
        src_v = 1'b1;
        src_d = 16'($urandom);
      end
      pd_r = ($urandom_range(0, 1) == 1);
      step(mk(0, src_v, pd_r, src_d, src_v, pd_r, src_d, 0, 5'b00000, "pass"));
      if (src_v && pd_r) begin
        sent++;
        src_v = 1'b0;
      end
      cyc++;
    end
    chk("pass_in_count_100", in_count, 32'd100);
    chk("pass_out_count_100", out_count, 32'd100);

    // Three-entry FIFO DUT model exercises the stored scoreboard path.
    step(mk(1, 0, 0, 16'h0, 0, 0, 16'h0, 0, 5'b00000, "rst_fifo"));
    src_v = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!src_v && $urandom_range(0, 2) != 0) begin
        src_v = 1'b1;
        src_d = 16'($urandom);
      end
      cdr    = (fq.size() < 3);
      ps_r   = (fq.size() > 0);
      pdat_r = ps_r ? fq[0] : 16'h0;
      pd_r   = ($urandom_range(0, 3) != 0);
      ci     = src_v & cdr;
      po     = ps_r & pd_r;
      if (po) void'(fq.pop_front());
      if (ci) fq.push_back(src_d);
      step(mk(0, src_v, cdr, src_d, ps_r, pd_r, pdat_r, 3'(fq.size()), 5'b00000, "fifo"));
      if (ci) src_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_flow_checker.md
Name: sd_flow_checker

Overview:
- Parametrised srdy/drdy flow checker; bolts onto any single-input/single-output sd block in a formal or simulation bench.
- Monitors the consumer-side (c_*) and producer-side (p_*) handshakes of the DUT.
- Keeps transfer counts and an in-order scoreboard of expected data.
- Flags protocol, ordering, capacity and liveness violations on sticky error outputs.

Parameters:
- width, 16, data bus width in bits.
- depth, 8, scoreboard entries; maximum items the DUT may hold in flight.
- max_latency, 32, ready cycles an item may wait at the output before a timeout; 0 disables the check.
- check_data, 1, 1 = compare p_data against the scoreboard; 0 = count-only mode, no data storage.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- c_srdy  input  1  DUT consumer-side source ready.
- c_drdy  input  1  DUT consumer-side destination ready.
- c_data  input  width  DUT input data.
- p_srdy  input  1  DUT producer-side source ready.
- p_drdy  input  1  DUT producer-side destination ready.
- p_data  input  width  DUT output data.
- in_count  output  32  input transfers since reset.
- out_count  output  32  output transfers since reset.
- occupancy  output  $clog2(depth+1)  items currently in flight.
- err_hold  output  1  sticky: producer dropped srdy or changed data while stalled.
- err_order  output  1  sticky: output data mismatch.
- err_overflow  output  1  sticky: more than depth items in flight.
- err_underflow  output  1  sticky: output with nothing in flight.
- err_timeout  output  1  sticky: liveness violation.
- err  output  1  OR of all sticky errors.

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on port reset.
- Reset: all counts, occupancy, scoreboard pointers and error flags go to 0.
- Reset applied mid-operation discards all in-flight entries. The first cycle after reset deasserts starts from empty.
- Transfer definitions:
  - input transfer ci = c_srdy & c_drdy.
  - output transfer po = p_srdy & p_drdy.
- All outputs are registered. An error flag rises the cycle after the offending edge and stays high until reset.
- in_count and out_count increment on ci and po respectively, and wrap modulo 2^32 without error.
- Scoreboard:
  - Circular buffer of depth entries with read/write pointers that wrap at depth.
  - ci pushes c_data. po pops the head.
  - occupancy changes by ci - po per cycle.
- Simultaneous ci and po with occupancy 0 (bypass): compare p_data against c_data directly. Occupancy stays 0 and there is no underflow.
- Simultaneous ci and po with 0 < occupancy <= depth: pop the head and push the new data in the same cycle. Occupancy is unchanged.
- Overflow: ci without po while occupancy == depth sets err_overflow. The data is dropped and occupancy saturates at depth.
- Underflow: po while occupancy == 0 and no ci sets err_underflow. No compare is made and occupancy stays 0.
- Order check: when check_data = 1, po with p_data != expected data sets err_order. The entry is popped regardless.
- When check_data = 0, the scoreboard stores nothing and err_order stays 0. Occupancy and counts still operate.
- Hold check:
  - If p_srdy & !p_drdy in cycle t, then in cycle t+1 p_srdy must be 1 and p_data must equal its cycle-t value; otherwise err_hold is set.
  - A reset asserted at t+1 suppresses the check.
- Timeout:
  - A wait counter increments in cycles where occupancy > 0, p_drdy = 1 and no po occurs.
  - It clears on po, on occupancy == 0, and on reset. It holds in cycles where p_drdy = 0, so backpressure is never blamed on the DUT.
  - err_timeout is set when the counter reaches max_latency, and the counter saturates there.
- The checker never drives the DUT. All ports except the counts and flags are inputs.
- Formal use: each err_* also has an immediate assert under !reset, guarded by an ifdef FORMAL.

Test Plan:
- Passthrough DUT, 100 random items with random c_srdy/p_drdy: in_count = out_count = 100, occupancy = 0, err = 0.
- depth = 4, push 5 items while holding p_drdy = 0: occupancy = 4 and err_overflow rises the cycle after the 5th ci.
- Push 0x1234 and 0x5678, then DUT emits 0x5678 first: err_order = 1 the following cycle; occupancy goes from 2 to 1.
- p_srdy = 1, p_drdy = 0, p_data = 0xAAAA at t; p_data = 0xAAAB at t+1: err_hold = 1 at t+2; no other flag set.
- max_latency = 8, one item in flight, p_drdy = 1 and DUT never asserts p_srdy: err_timeout = 1 after 8 ready cycles; with p_drdy held at 0, no timeout ever.
- Reset pulsed with 3 items in flight and err_order set: next cycle all counts, occupancy and flags are 0; a fresh item then passes cleanly.
